// File: rtl/pipe_stall_ctrl.sv
// Stall/flush scheduler for the five-stage pipeline: combinational stage enables,
// stall-classification FSM, saturating stall counters and a cache-miss watchdog.
module pipe_stall_ctrl #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ic_stall,
    input  logic             dc_stall,
    input  logic             ld_use_hazard,
    input  logic             branch_taken,
    input  logic             clr_cnt,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_write,
    output logic             ex_m_write,
    output logic             m_wb_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic [1:0]       stall_state,
    output logic [CNT_W-1:0] ic_stall_cnt,
    output logic [CNT_W-1:0] dc_stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic             err_timeout
);

    localparam int unsigned WaitW = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CntMax = '1;

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StIStall = 2'd1,
        StDStall = 2'd2,
        StHalt   = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [WaitW-1:0] wait_q, wait_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] ic_cnt_q, ic_cnt_d;
    logic [CNT_W-1:0] dc_cnt_q, dc_cnt_d;
    logic [CNT_W-1:0] bub_cnt_q, bub_cnt_d;

    logic halt;
    logic any_stall;
    logic trip;
    logic ld_row;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CntMax) ? v : v + CNT_W'(1);
    endfunction

    assign halt      = (state_q == StHalt);
    assign any_stall = ic_stall | dc_stall;
    assign trip      = !halt && any_stall && (wait_q == WaitW'(TIMEOUT - 1));
    // Load-use row only wins when nothing of higher priority is active.
    assign ld_row    = !halt && !dc_stall && !branch_taken && !ic_stall && ld_use_hazard;

    always_comb begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        id_ex_write = 1'b1;
        ex_m_write  = 1'b1;
        m_wb_write  = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        if (rst || halt || dc_stall) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_write = 1'b0;
            ex_m_write  = 1'b0;
            m_wb_write  = 1'b0;
        end else if (branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (ic_stall || ld_use_hazard) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        err_d     = err_q;
        ic_cnt_d  = ic_cnt_q;
        dc_cnt_d  = dc_cnt_q;
        bub_cnt_d = bub_cnt_q;
        if (!halt) begin
            if (trip) begin
                state_d = StHalt;
                err_d   = 1'b1;
            end else if (dc_stall) begin
                state_d = StDStall;
            end else if (ic_stall) begin
                state_d = StIStall;
            end else begin
                state_d = StRun;
            end
            wait_d = any_stall ? wait_q + WaitW'(1) : '0;
            if (dc_stall)             dc_cnt_d  = sat_inc(dc_cnt_q);
            if (ic_stall && !dc_stall) ic_cnt_d = sat_inc(ic_cnt_q);
            if (ld_row)               bub_cnt_d = sat_inc(bub_cnt_q);
        end
        if (clr_cnt) begin
            ic_cnt_d  = '0;
            dc_cnt_d  = '0;
            bub_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StRun;
            wait_q    <= '0;
            err_q     <= 1'b0;
            ic_cnt_q  <= '0;
            dc_cnt_q  <= '0;
            bub_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            err_q     <= err_d;
            ic_cnt_q  <= ic_cnt_d;
            dc_cnt_q  <= dc_cnt_d;
            bub_cnt_q <= bub_cnt_d;
        end
    end

    assign stall_state  = state_q;
    assign err_timeout  = err_q;
    assign ic_stall_cnt = ic_cnt_q;
    assign dc_stall_cnt = dc_cnt_q;
    assign bubble_cnt   = bub_cnt_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Randomised + directed bench for pipe_stall_ctrl: two instances (small counters /
// short watchdog) checked every cycle against a behavioural model.
module tb_pipe_stall_ctrl;

    logic clk = 1'b0;
    logic ic, dc, ld, bt, clr, rst_a, rst_b;

    logic pc_a, ifid_a, idex_a, exm_a, mwb_a, fifid_a, fidex_a, err_a;
    logic pc_b, ifid_b, idex_b, exm_b, mwb_b, fifid_b, fidex_b, err_b;
    logic [1:0]  st_a, st_b;
    logic [2:0]  icc_a, dcc_a, bub_a;
    logic [15:0] icc_b, dcc_b, bub_b;

    int checks   = 0;
    int failures = 0;

    // Model state per instance: 0 = CNT_W 3 / TIMEOUT 16, 1 = CNT_W 16 / TIMEOUT 4
    int m_state[2], m_run[2], m_ic[2], m_dc[2], m_bub[2], m_err[2];
    int tmo[2]  = '{16, 4};
    int cmax[2] = '{7, 65535};

    always #5 clk = ~clk;

    pipe_stall_ctrl #(.CNT_W(3), .TIMEOUT(16)) dut_a (
        .clk(clk), .rst(rst_a), .ic_stall(ic), .dc_stall(dc), .ld_use_hazard(ld),
        .branch_taken(bt), .clr_cnt(clr), .pc_write(pc_a), .if_id_write(ifid_a),
        .id_ex_write(idex_a), .ex_m_write(exm_a), .m_wb_write(mwb_a),
        .if_id_flush(fifid_a), .id_ex_flush(fidex_a), .stall_state(st_a),
        .ic_stall_cnt(icc_a), .dc_stall_cnt(dcc_a), .bubble_cnt(bub_a),
        .err_timeout(err_a)
    );

    pipe_stall_ctrl #(.CNT_W(16), .TIMEOUT(4)) dut_b (
        .clk(clk), .rst(rst_b), .ic_stall(ic), .dc_stall(dc), .ld_use_hazard(ld),
        .branch_taken(bt), .clr_cnt(clr), .pc_write(pc_b), .if_id_write(ifid_b),
        .id_ex_write(idex_b), .ex_m_write(exm_b), .m_wb_write(mwb_b),
        .if_id_flush(fifid_b), .id_ex_flush(fidex_b), .stall_state(st_b),
        .ic_stall_cnt(icc_b), .dc_stall_cnt(dcc_b), .bubble_cnt(bub_b),
        .err_timeout(err_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Enable table ordered {pc, if_id, id_ex, ex_m, m_wb, if_id_flush, id_ex_flush}.
    function automatic logic [6:0] exp_en(input bit frozen);
        if (frozen || dc)  return 7'b00000_00;
        if (bt)            return 7'b11111_11;
        if (ic || ld)      return 7'b00111_01;
        return 7'b11111_00;
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v + 1 > mx) ? mx : v + 1;
    endfunction

    task automatic model_reset(input int d);
        m_state[d] = 0; m_run[d] = 0; m_ic[d] = 0; m_dc[d] = 0; m_bub[d] = 0; m_err[d] = 0;
    endtask

    task automatic model_update(input int d, input bit r);
        bit halted;
        if (r) begin
            model_reset(d);
            return;
        end
        halted = (m_state[d] == 3);
        if (!halted) begin
            if (dc)       m_dc[d] = sat(m_dc[d], cmax[d]);
            if (ic && !dc) m_ic[d] = sat(m_ic[d], cmax[d]);
            if (ld && !ic && !dc && !bt) m_bub[d] = sat(m_bub[d], cmax[d]);
            if (ic || dc) begin
                m_run[d]++;
                if (m_run[d] >= tmo[d]) begin
                    m_state[d] = 3;
                    m_err[d]   = 1;
                end else begin
                    m_state[d] = dc ? 2 : 1;
                end
            end else begin
                m_run[d]   = 0;
                m_state[d] = 0;
            end
        end
        if (clr) begin
            m_ic[d] = 0; m_dc[d] = 0; m_bub[d] = 0;
        end
    endtask

    task automatic check_dut(input string p, input int d, input bit r, input logic [6:0] en,
                             input logic [1:0] st, input int icc, input int dcc,
                             input int bub, input logic err);
        check_eq({p, "enables"}, en, exp_en(r || m_state[d] == 3));
        check_eq({p, "stall_state"}, st, m_state[d]);
        check_eq({p, "ic_stall_cnt"}, icc, m_ic[d]);
        check_eq({p, "dc_stall_cnt"}, dcc, m_dc[d]);
        check_eq({p, "bubble_cnt"}, bub, m_bub[d]);
        check_eq({p, "err_timeout"}, err, m_err[d]);
    endtask

    task automatic step(input bit ic_i, input bit dc_i, input bit ld_i, input bit bt_i,
                        input bit clr_i, input bit ra, input bit rb);
        ic = ic_i; dc = dc_i; ld = ld_i; bt = bt_i; clr = clr_i; rst_a = ra; rst_b = rb;
        if (ra) model_reset(0);
        if (rb) model_reset(1);
        @(negedge clk);
        check_dut("a_", 0, ra, {pc_a, ifid_a, idex_a, exm_a, mwb_a, fifid_a, fidex_a},
                  st_a, icc_a, dcc_a, bub_a, err_a);
        check_dut("b_", 1, rb, {pc_b, ifid_b, idex_b, exm_b, mwb_b, fifid_b, fidex_b},
                  st_b, icc_b, dcc_b, bub_b, err_b);
        @(posedge clk);
        model_update(0, ra);
        model_update(1, rb);
        #1;
    endtask

    initial begin
        int p_stall;
        bit ra, rb;
        ic = 0; dc = 0; ld = 0; bt = 0; clr = 0; rst_a = 1; rst_b = 1;
        model_reset(0);
        model_reset(1);

        step(0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 1, 1);
        repeat (5) step(0, 0, 0, 0, 0, 0, 0);
        check_eq("idle_state", st_a, 2'd0);
        check_eq("idle_pc_write", pc_a, 1'b1);

        // D-cache stall with an overlapping I-cache stall in the middle cycle
        step(0, 1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        check_eq("dstall_state", st_a, 2'd2);
        step(0, 0, 0, 0, 0, 0, 0);
        check_eq("dstall_dc_cnt", dcc_a, 3'd3);
        check_eq("dstall_ic_cnt", icc_a, 3'd0);
        check_eq("dstall_back_run", st_a, 2'd0);

        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        check_eq("ld_use_bubble", bub_a, 3'd1);
        step(0, 0, 1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        check_eq("ld_use_branch_bubble", bub_a, 3'd1);

        step(1, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        check_eq("ic_branch_ic_cnt", icc_a, 3'd1);

        // Watchdog on the short-timeout instance
        repeat (4) step(0, 1, 0, 0, 0, 0, 0);
        check_eq("wd_halt_state", st_b, 2'd3);
        check_eq("wd_err", err_b, 1'b1);
        check_eq("wd_other_state", st_a, 2'd2);
        repeat (3) step(0, 0, 0, 0, 0, 0, 0);
        check_eq("halt_absorbing", st_b, 2'd3);
        check_eq("halt_pc_write", pc_b, 1'b0);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0);
        check_eq("halt_rst_state", st_b, 2'd0);
        check_eq("halt_rst_err", err_b, 1'b0);

        // Saturation on the narrow-counter instance
        repeat (10) step(0, 1, 0, 0, 0, 0, 0);
        check_eq("sat_dc_cnt", dcc_a, 3'd7);
        check_eq("halt_no_count", dcc_b, 16'd4);
        step(0, 0, 0, 0, 1, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0);
        check_eq("clr_dc_cnt", dcc_a, 3'd0);

        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) p_stall = ((i / 200) % 2 == 0) ? 20 : 65;
            ra = (m_state[0] == 3 && $urandom_range(0, 7) == 0) || $urandom_range(0, 199) == 0;
            rb = (m_state[1] == 3 && $urandom_range(0, 7) == 0) || $urandom_range(0, 199) == 0;
            step($urandom_range(0, 99) < p_stall, $urandom_range(0, 99) < p_stall,
                 $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 15,
                 $urandom_range(0, 49) == 0, ra, rb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Central stall/flush scheduler for the five-stage pipeline. It drives the write enables of the PC and of the IF/ID, ID/EX, EX/M and M/WB pipeline registers, and the bubble-insert flushes of IF/ID and ID/EX. Inputs are cache-miss stalls, the load-use hazard and taken-branch redirects. It also classifies stall cycles in a small FSM, keeps saturating performance counters, and runs a miss watchdog that freezes the core on a hung cache.

## Interface

Parameters:
- CNT_W, 16: width of each performance counter.
- TIMEOUT, 1024: number of consecutive stalled posedges that trips the watchdog (≥2).

Ports:
- clk  in  1  core clock; FSM and counters on posedge, pipeline registers sample enables on negedge.
- rst  in  1  reset, asynchronous, active-high.
- ic_stall  in  1  I-cache not ready (fetch miss outstanding).
- dc_stall  in  1  D-cache not ready for MEM-stage access.
- ld_use_hazard  in  1  load in EX feeds instruction in ID (from hazard detect).
- branch_taken  in  1  EX-stage redirect; younger IF/ID, ID/EX contents are wrong-path.
- clr_cnt  in  1  synchronous clear of the three performance counters.
- pc_write, if_id_write, id_ex_write, ex_m_write, m_wb_write  out  1 each  stage write enables (combinational).
- if_id_flush, id_ex_flush  out  1 each  load a bubble (flush implies write) (combinational).
- stall_state  out  2  FSM state: 0 RUN, 1 ISTALL, 2 DSTALL, 3 HALT.
- ic_stall_cnt, dc_stall_cnt, bubble_cnt  out  CNT_W each  saturating cycle counters.
- err_timeout  out  1  registered; 1 while in HALT.

## Operation

Enable priority (combinational, first match wins):
- rst=1 or state HALT: all five writes 0, both flushes 0 (pipeline frozen).
- dc_stall=1: all five writes 0, flushes 0.
- branch_taken=1: all writes 1, if_id_flush=1, id_ex_flush=1. This overrides ic_stall (PC redirect must not be lost) and ld_use_hazard (dependent instruction is wrong-path).
- ic_stall=1: pc_write=0, if_id_write=0, id_ex_flush=1; id_ex_write, ex_m_write, m_wb_write 1 (back end drains).
- ld_use_hazard=1: pc_write=0, if_id_write=0, id_ex_flush=1; rest 1.
- otherwise: all writes 1, flushes 0.

FSM (posedge, next state from sampled inputs):
- Any state except HALT: watchdog fires → HALT; else dc_stall → DSTALL; else ic_stall → ISTALL; else RUN.
- dc_stall wins over ic_stall when both are high.
- HALT is absorbing; only rst leaves it.

Watchdog:
- wait_cnt (internal, ≥ log2(TIMEOUT)+1 bits) increments on each posedge with (ic_stall|dc_stall)=1 outside HALT.
- It clears on any posedge where both are 0.
- Posedge with a stall high and wait_cnt==TIMEOUT-1 → HALT and err_timeout=1 on that edge.

Counters (posedge, saturate at 2^CNT_W−1, never wrap):
- dc_stall_cnt +1 when dc_stall.
- ic_stall_cnt +1 when ic_stall and not dc_stall.
- bubble_cnt +1 when the ld_use row is selected.
- No counting in HALT.
- clr_cnt zeroes all three; clr_cnt wins over a same-cycle increment.

## Timing

- Reset values: stall_state 0 (RUN), all counters 0, wait_cnt 0, err_timeout 0. Enables are per the rst row while rst is high.
- Enables have zero latency: they are valid the same cycle as the inputs and are sampled at the next negedge. Cache/hazard inputs must settle before the negedge.
- stall_state and counters lag inputs by one posedge.
- A stall of N consecutive posedges (N < TIMEOUT) adds exactly N to the relevant counter, then returns to RUN.
- Reset asserted mid-stall or in HALT: immediate return to reset values. No pending state survives.
- Single-cycle glitches on stall inputs are honoured; there is no filtering.

## Test plan

- Reset, then idle inputs for 5 cycles → all writes 1, flushes 0, stall_state 0, counters 0.
- dc_stall high for 3 posedges, with ic_stall also high in cycle 2 → all writes 0 for those 3 cycles, stall_state 2, 2, 2 then 0, dc_stall_cnt=3, ic_stall_cnt=0.
- ld_use_hazard for 1 cycle → pc_write=0, if_id_write=0, id_ex_flush=1, m_wb_write=1; bubble_cnt=1. Repeat with branch_taken also high → flush row, bubble_cnt unchanged.
- ic_stall plus branch_taken in the same cycle → pc_write=1, if_id_flush=1, id_ex_flush=1; ic_stall_cnt +1.
- TIMEOUT=4, dc_stall held high → HALT and err_timeout=1 on the 4th posedge. Dropping dc_stall keeps HALT and all writes 0; rst returns to RUN.
- CNT_W=3, dc_stall for 10 cycles (TIMEOUT=16) → dc_stall_cnt saturates at 7. clr_cnt then gives 0.
